// File: rtl/ysyx_22040895_fetch_ctrl_pkg.sv
// ysyx_22040895_fetch_ctrl_pkg: shared fetch FSM encodings, reset PC default and next-PC select codes.
package ysyx_22040895_fetch_ctrl_pkg;
   typedef enum logic [1:0] {ST_BOOT, ST_REQ, ST_WAIT, ST_VALID} state_e;
   typedef enum logic [1:0] {SEL_SEQ, SEL_BRANCH, SEL_TRAP} sel_e;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
   localparam int INST_BYTES = 4;
endpackage

// File: rtl/ysyx_22040895_npc_sel.sv
// ysyx_22040895_npc_sel: next-PC priority mux (trap > branch/jump redirect > sequential).
module ysyx_22040895_npc_sel
   import ysyx_22040895_fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic              trap,
   input  logic [ADDR_W-1:0] trap_vec,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] dnpc,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next_pc,
   output logic              redirect_any
);
   sel_e sel;
   always_comb begin
      sel = trap ? SEL_TRAP : redirect ? SEL_BRANCH : SEL_SEQ;
      next_pc = sel == SEL_TRAP ? trap_vec : sel == SEL_BRANCH ? dnpc : pc + ADDR_W'(INST_BYTES);
      redirect_any = sel != SEL_SEQ;
   end
endmodule

// File: rtl/ysyx_22040895_fetch_ctrl.sv
// ysyx_22040895_fetch_ctrl: stall-aware, redirect-safe instruction fetch sequencer.
// Define YSYX_22040895_MISALIGN_CHK_EN to hold misaligned redirect targets until a trap.
module ysyx_22040895_fetch_ctrl
   import ysyx_22040895_fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [INST_W-1:0] imem_rdata_i,
   output logic              inst_valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   input  logic              inst_ready_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] dnpc_i,
   input  logic              trap_i,
   input  logic [ADDR_W-1:0] trap_vec_i,
   output logic              ce_o,
   output logic              misalign_o
);
   state_e state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, next_pc;
   logic [INST_W-1:0] inst, inst_n;
   logic kill, kill_n, ce, redir, misal;

   ysyx_22040895_npc_sel #(.ADDR_W(ADDR_W)) u_npc_sel (
      .trap(trap_i),
      .trap_vec(trap_vec_i),
      .redirect(redirect_i),
      .dnpc(dnpc_i),
      .pc(pc),
      .next_pc(next_pc),
      .redirect_any(redir)
   );

   assign imem_req_o = state == ST_REQ && !misal;
   assign imem_addr_o = pc;
   assign pc_o = pc;
   assign inst_o = inst;
   assign inst_valid_o = state == ST_VALID;
   assign ce_o = ce;
   assign misalign_o = misal;

   always_comb begin
      state_n = state;
      pc_n = pc;
      inst_n = inst;
      kill_n = kill;
      case (state)
         ST_BOOT: state_n = ST_REQ;
         ST_REQ: begin
            if (redir) pc_n = next_pc;
            // a grant alongside a redirect means the stale address is already in flight
            if (imem_req_o && imem_gnt_i) begin
               state_n = ST_WAIT;
               kill_n = redir;
            end
         end
         ST_WAIT: begin
            if (redir) pc_n = next_pc;
            if (imem_rvalid_i) begin
               kill_n = 1'b0;
               state_n = (kill || redir) ? ST_REQ : ST_VALID;
               inst_n = (kill || redir) ? inst : imem_rdata_i;
            end else if (redir) kill_n = 1'b1;
         end
         ST_VALID: begin
            if (redir || inst_ready_i) begin
               pc_n = next_pc;
               state_n = ST_REQ;
            end
         end
         default: state_n = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= ST_BOOT;
         pc <= RESET_PC;
         inst <= '0;
         kill <= 1'b0;
         ce <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         inst <= inst_n;
         kill <= kill_n;
         ce <= ce | (state == ST_BOOT);
      end

`ifdef YSYX_22040895_MISALIGN_CHK_EN
   // only a trap can release a parked misaligned redirect
   always_ff @(posedge clk or negedge rst)
      if (!rst) misal <= 1'b0;
      else if (state != ST_BOOT) misal <= trap_i ? 1'b0 : misal | (redirect_i && dnpc_i[1:0] != 2'd0);
`else
   assign misal = 1'b0;
`endif
endmodule

// File: tb/tb_ysyx_22040895_fetch_ctrl.sv
// tb_ysyx_22040895_fetch_ctrl: scoreboard bench with a latency-configurable IMEM responder.
module tb_ysyx_22040895_fetch_ctrl;
   localparam logic [63:0] BAD = 64'hdead_dead_dead_dead;
   typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;

   logic clk = 1'b0, rst = 1'b0;
   logic imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
   logic [63:0] imem_addr_o, pc_o, dnpc_i = '0, trap_vec_i = '0;
   logic [31:0] imem_rdata_i = '0, inst_o;
   logic inst_valid_o, inst_ready_i = 1'b0, redirect_i = 1'b0, trap_i = 1'b0, ce_o, misalign_o;

   int n_chk = 0, n_err = 0, n_cons = 0, lat = 1, cnt = 0, k;
   logic gnt_en = 1'b1, pend = 1'b0;
   logic [63:0] pa = '0, nxt;
   logic [63:0] qa[$];
   exp_t qi[$];

   ysyx_22040895_fetch_ctrl dut (
      .clk(clk), .rst(rst),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .inst_valid_o(inst_valid_o), .inst_o(inst_o), .pc_o(pc_o), .inst_ready_i(inst_ready_i),
      .redirect_i(redirect_i), .dnpc_i(dnpc_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
      .ce_o(ce_o), .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_i(input logic [63:0] p);
      qi.push_back('{p, mem(p)});
   endtask

   // drive IMEM for the current cycle, score grants and consumes, advance one clock
   task automatic cyc();
      logic [63:0] e;
      exp_t x;
      imem_rvalid_i = 1'b0;
      if (pend && cnt == 0) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i = mem(pa);
         pend = 1'b0;
      end else if (pend) cnt--;
      imem_gnt_i = imem_req_o && gnt_en;
      if (imem_gnt_i) begin
         e = BAD;
         if (qa.size() != 0) e = qa.pop_front();
         chk("req_addr", imem_addr_o, e);
         pend = 1'b1;
         cnt = lat - 1;
         pa = imem_addr_o;
      end
      if (inst_valid_o && inst_ready_i) begin
         x = '{BAD, 32'hdead_beef};
         if (qi.size() != 0) x = qi.pop_front();
         chk("cons_pc", pc_o, x.pc);
         chk("cons_inst", {32'd0, inst_o}, {32'd0, x.inst});
         n_cons++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid();
      int i = 0;
      while (!inst_valid_o && i < 40) begin
         cyc();
         i++;
      end
      chk("wait_valid", {63'd0, inst_valid_o}, 64'd1);
   endtask

   task automatic consume();
      inst_ready_i = 1'b1;
      cyc();
      inst_ready_i = 1'b0;
   endtask

   task automatic chk_reset();
      chk("rst_pc", pc_o, 64'h8000_0000);
      chk("rst_req", {63'd0, imem_req_o}, 64'd0);
      chk("rst_valid", {63'd0, inst_valid_o}, 64'd0);
      chk("rst_inst", {32'd0, inst_o}, 64'd0);
      chk("rst_ce", {63'd0, ce_o}, 64'd0);
      chk("rst_misalign", {63'd0, misalign_o}, 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_reset();
      // 1: zero-wait streaming from reset
      rst = 1'b1;
      qa.push_back(64'h8000_0000); qa.push_back(64'h8000_0004);
      qa.push_back(64'h8000_0008); qa.push_back(64'h8000_000c);
      push_i(64'h8000_0000); push_i(64'h8000_0004); push_i(64'h8000_0008);
      chk("ce_boot", {63'd0, ce_o}, 64'd0);
      inst_ready_i = 1'b1;
      k = 0;
      while (!inst_valid_o && k < 20) begin
         cyc();
         k++;
      end
      chk("first_valid_lat", 64'(k), 64'd3);
      chk("ce_on", {63'd0, ce_o}, 64'd1);
      k = 0;
      while (n_cons < 3 && k < 30) begin
         cyc();
         k++;
      end
      chk("three_inst_cycles", 64'(k), 64'd7);
      inst_ready_i = 1'b0;
      // 2: decode stall holds the instruction and blocks further fetch
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         chk("stall_pc", pc_o, 64'h8000_000c);
         chk("stall_inst", {32'd0, inst_o}, {32'd0, mem(64'h8000_000c)});
         chk("stall_req", {63'd0, imem_req_o}, 64'd0);
         cyc();
      end
      push_i(64'h8000_000c);
      qa.push_back(64'h8000_0010);
      consume();
      // 3: redirect while waiting on memory discards the response
      wait_valid();
      lat = 3;
      push_i(64'h8000_0010);
      qa.push_back(64'h8000_0014);
      consume();
      cyc();
      qa.push_back(64'h8000_1000);
      redirect_i = 1'b1;
      dnpc_i = 64'h8000_1000;
      cyc();
      redirect_i = 1'b0;
      chk("wait_redir_novalid", {63'd0, inst_valid_o}, 64'd0);
      wait_valid();
      chk("redir_pc", pc_o, 64'h8000_1000);
      // 4: trap beats redirect and sequential even with a consume
      push_i(64'h8000_1000);
      qa.push_back(64'h8000_2000);
      trap_i = 1'b1; trap_vec_i = 64'h8000_2000;
      redirect_i = 1'b1; dnpc_i = 64'h8000_3000;
      inst_ready_i = 1'b1;
      cyc();
      trap_i = 1'b0; redirect_i = 1'b0; inst_ready_i = 1'b0;
      chk("trap_addr", imem_addr_o, 64'h8000_2000);
      chk("trap_req", {63'd0, imem_req_o}, 64'd1);
      wait_valid();
      // 5: reset in WAIT, stray response lands in BOOT
      lat = 2;
      push_i(64'h8000_2000);
      qa.push_back(64'h8000_2004);
      consume();
      cyc();
      rst = 1'b0;
      #1;
      chk_reset();
      cyc();
      rst = 1'b1;
      chk("boot_ce", {63'd0, ce_o}, 64'd0);
      lat = 1;
      qa.push_back(64'h8000_0000);
      cyc();
      chk("boot_novalid", {63'd0, inst_valid_o}, 64'd0);
      wait_valid();
      push_i(64'h8000_0000);
      qa.push_back(64'h8000_0004);
      consume();
      wait_valid();
      // 6: misaligned redirect target
      redirect_i = 1'b1;
      dnpc_i = 64'h8000_0102;
`ifdef YSYX_22040895_MISALIGN_CHK_EN
      cyc();
      redirect_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("misal_flag", {63'd0, misalign_o}, 64'd1);
         chk("misal_noreq", {63'd0, imem_req_o}, 64'd0);
         cyc();
      end
      qa.push_back(64'h8000_0200);
      trap_i = 1'b1;
      trap_vec_i = 64'h8000_0200;
      cyc();
      trap_i = 1'b0;
      chk("misal_clr", {63'd0, misalign_o}, 64'd0);
      wait_valid();
      push_i(64'h8000_0200);
      nxt = 64'h8000_0204;
`else
      qa.push_back(64'h8000_0102);
      cyc();
      redirect_i = 1'b0;
      chk("misal_off", {63'd0, misalign_o}, 64'd0);
      chk("unchk_addr", imem_addr_o, 64'h8000_0102);
      wait_valid();
      push_i(64'h8000_0102);
      nxt = 64'h8000_0106;
`endif
      gnt_en = 1'b0;
      consume();
      // 7: redirect in REQ without grant, then with a same-cycle grant
      for (int i = 0; i < 2; i++) begin
         chk("req_hold_addr", imem_addr_o, nxt);
         chk("req_hold_req", {63'd0, imem_req_o}, 64'd1);
         cyc();
      end
      redirect_i = 1'b1;
      dnpc_i = 64'h8000_4000;
      cyc();
      redirect_i = 1'b0;
      chk("req_redir_addr", imem_addr_o, 64'h8000_4000);
      gnt_en = 1'b1;
      qa.push_back(64'h8000_4000);
      wait_valid();
      push_i(64'h8000_4000);
      qa.push_back(64'h8000_4004);
      qa.push_back(64'h8000_5000);
      consume();
      redirect_i = 1'b1;
      dnpc_i = 64'h8000_5000;
      cyc();
      redirect_i = 1'b0;
      wait_valid();
      push_i(64'h8000_5000);
      gnt_en = 1'b0;
      consume();
      chk("q_addr_left", 64'(qa.size()), 64'd0);
      chk("q_inst_left", 64'(qi.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
